sfft_frame_readout: RTL

//  Ping-pong frame buffer between the SFFT pipeline and the HPS bus. Captures a serial stream of

---
 rtl/sfft_readout_pkg.sv | 46 ++++
 rtl/sfft_bank_ram.sv | 27 ++
 rtl/sfft_frame_readout.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/sfft_readout_pkg.sv
// Shared types and register-map constants for the SFFT frame readout block.
// TEST_PATTERN_EN enables the fixed loopback words just below the STATUS/CTRL address.
package sfft_readout_pkg;

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_DISCARD = 2'd1,
        ST_HOLD    = 2'd2
    } wr_state_e;

    localparam int unsigned ADDR_FRAMECNT = 0;
    localparam int unsigned ADDR_BIN_BASE = 1;
    // STATUS/CTRL sits at 2**ADDR_W - ADDR_TOP_OFS
    localparam int unsigned ADDR_TOP_OFS  = 1;
    localparam int unsigned TP_WORDS      = 8;

    localparam int unsigned CTRL_LOCK     = 0;
    localparam int unsigned CTRL_CLEAR    = 1;

    localparam int unsigned STAT_LOCKED   = 0;
    localparam int unsigned STAT_PENDING  = 1;
    localparam int unsigned STAT_HAVE     = 2;
    localparam int unsigned STAT_ERR      = 3;
    localparam int unsigned STAT_OVR_LSB  = 16;

    localparam logic [31:0] TEST_PATTERN [TP_WORDS] = '{
        32'h0000_0000, 32'h0000_00FF, 32'hFF00_00F0, 32'h0000_00B2,
        32'h0001_1170, 32'h0003_D090, 32'h0007_5300, 32'h000E_A600
    };

    function automatic logic [31:0] pack_status(input logic [15:0] ovr,
                                                input logic        err,
                                                input logic        have,
                                                input logic        pend,
                                                input logic        lock);
        logic [31:0] s;
        s = 32'd0;
        s[STAT_OVR_LSB +: 16] = ovr;
        s[STAT_ERR]           = err;
        s[STAT_HAVE]          = have;
        s[STAT_PENDING]       = pend;
        s[STAT_LOCKED]        = lock;
        return s;
    endfunction

endpackage

// File: rtl/sfft_bank_ram.sv
// Simple dual-port ping-pong bin store: one write port, one registered read port.
// Bank select is the address MSB; read data holds when rd_en is low.
module sfft_bank_ram #(
    parameter int unsigned ADDR_BITS = 9,
    parameter int unsigned DATA_W    = 32
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [DATA_W-1:0]    rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sfft_frame_readout.sv
// Ping-pong frame buffer between the SFFT bin stream and the HPS bus, with host lock.
// Optional TEST_PATTERN_EN maps fixed loopback words at TOP-8..TOP-1.
module sfft_frame_readout
    import sfft_readout_pkg::*;
#(
    parameter int unsigned NFFT   = 256,
    parameter int unsigned BIN_W  = 32,
    parameter int unsigned TIME_W = 32,
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned OVR_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [BIN_W-1:0]  in_data,
    input  logic              in_last,
    input  logic              chipselect,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              frame_irq
);

    localparam int unsigned IDX_W   = (NFFT > 1) ? $clog2(NFFT) : 1;
    localparam int unsigned TOP     = (1 << ADDR_W) - ADDR_TOP_OFS;
    localparam int unsigned TP_BASE = TOP - TP_WORDS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NFFT - 1);

    wr_state_e         state;
    logic [IDX_W-1:0]  idx;
    logic              rsel;
    logic              locked, pending, have_frame, err, mid;
    logic [OVR_W-1:0]  ovr;
    logic [TIME_W-1:0] frame_cnt, rd_cnt;
    logic              rd_src;
    logic [31:0]       rd_reg;
    logic [BIN_W-1:0]  ram_q;

    // Bus decode
    logic [31:0]      addr32;
    logic             rd_acc, ctrl_wr, is_bin;
    logic [IDX_W-1:0] rd_idx;
    logic [31:0]      reg_word;
    logic             unused_wdata;

    assign addr32       = 32'(address);
    assign rd_acc       = chipselect & ~write;
    assign ctrl_wr      = chipselect & write & (addr32 == TOP);
    assign is_bin       = (addr32 >= ADDR_BIN_BASE) && (addr32 < ADDR_BIN_BASE + NFFT);
    assign rd_idx       = IDX_W'(addr32 - ADDR_BIN_BASE);
    assign unused_wdata = &{1'b0, writedata[31:2]};

    always_comb begin
        reg_word = 32'd0;
        if (addr32 == ADDR_FRAMECNT) begin
            reg_word = 32'(rd_cnt);
        end else if (addr32 == TOP) begin
            reg_word = pack_status(16'(ovr), err, have_frame, pending, locked);
        end
`ifdef TEST_PATTERN_EN
        else if ((addr32 >= TP_BASE) && (addr32 < TOP)) begin
            reg_word = TEST_PATTERN[3'(addr32 - TP_BASE)];
        end
`endif
    end

    // Stream-side events
    logic commit, beat_err, ovr_inc, mid_next, release_hold, swap;

    assign commit       = (state == ST_FILL) && in_valid && in_last && (idx == LAST_IDX);
    assign beat_err     = (state == ST_FILL) && in_valid && (in_last != (idx == LAST_IDX));
    assign ovr_inc      = (state == ST_HOLD) && in_valid && in_last;
    assign mid_next     = in_valid ? ~in_last : mid;
    assign release_hold = (state == ST_HOLD) && !locked;
    assign swap         = (commit && !locked) || release_hold;

    // Bins land in the bank the host is not reading
    sfft_bank_ram #(
        .ADDR_BITS (IDX_W + 1),
        .DATA_W    (BIN_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (in_valid && (state == ST_FILL)),
        .wr_addr ({~rsel, idx}),
        .wr_data (in_data),
        .rd_en   (rd_acc && is_bin),
        .rd_addr ({rsel, rd_idx}),
        .rd_data (ram_q)
    );

    assign readdata = rd_src ? 32'(ram_q) : rd_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_FILL;
            idx        <= '0;
            rsel       <= 1'b0;
            locked     <= 1'b0;
            pending    <= 1'b0;
            have_frame <= 1'b0;
            err        <= 1'b0;
            mid        <= 1'b0;
            ovr        <= '0;
            frame_cnt  <= '0;
            rd_cnt     <= '0;
            frame_irq  <= 1'b0;
            rd_src     <= 1'b0;
            rd_reg     <= 32'd0;
        end else begin
            frame_irq <= swap;

            if (rd_acc) begin
                rd_src <= is_bin;
                rd_reg <= reg_word;
            end

            if (ctrl_wr) begin
                locked <= writedata[CTRL_LOCK];
            end

            if (ctrl_wr && writedata[CTRL_CLEAR]) begin
                err <= 1'b0;
                ovr <= '0;
            end else begin
                if (beat_err) begin
                    err <= 1'b1;
                end
                if (ovr_inc && (ovr != '1)) begin
                    ovr <= ovr + OVR_W'(1);
                end
            end

            if (commit) begin
                frame_cnt <= frame_cnt + TIME_W'(1);
            end

            if (swap) begin
                rsel       <= ~rsel;
                rd_cnt     <= commit ? frame_cnt + TIME_W'(1) : frame_cnt;
                have_frame <= 1'b1;
            end

            case (state)
                ST_FILL: begin
                    if (in_valid) begin
                        if (in_last) begin
                            idx <= '0;
                            if (commit && locked) begin
                                pending <= 1'b1;
                                mid     <= 1'b0;
                                state   <= ST_HOLD;
                            end
                        end else if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= ST_DISCARD;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                ST_DISCARD: begin
                    if (in_valid && in_last) begin
                        idx   <= '0;
                        state <= ST_FILL;
                    end
                end
                ST_HOLD: begin
                    mid <= mid_next;
                    if (!locked) begin
                        pending <= 1'b0;
                        state   <= mid_next ? ST_DISCARD : ST_FILL;
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end

endmodule
